// File: rtl/alu_flag_writeback.sv
// Writeback stage after the ALU: evaluates conditional execution against the
// architectural C/Z flags, updates them, and holds a register-file write until accepted.
module alu_flag_writeback #(
  parameter int WIDTH = 16,
  parameter int RA_W  = 3
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [1:0]       cz,
  input  logic [RA_W-1:0]  dest,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_carry,
  input  logic             alu_zero,
  input  logic [WIDTH-1:0] mem_data,
  output logic             rf_we,
  input  logic             rf_ready,
  output logic [RA_W-1:0]  rf_waddr,
  output logic [WIDTH-1:0] rf_wdata,
  output logic             pc_write,
  output logic             carry_flag,
  output logic             zero_flag,
  output logic             done,
  output logic             skipped
);

  typedef enum logic [1:0] {IDLE, EVAL, WRITE} state_t;

  localparam logic [3:0] OP_ADD  = 4'b0000;
  localparam logic [3:0] OP_ADI  = 4'b0001;
  localparam logic [3:0] OP_NAND = 4'b0010;
  localparam logic [3:0] OP_LHI  = 4'b0011;
  localparam logic [3:0] OP_LW   = 4'b0100;

  state_t state_reg, state_next;

  logic [3:0]       op_reg;
  logic [1:0]       cz_reg;
  logic [RA_W-1:0]  dest_reg;
  logic [WIDTH-1:0] alu_reg, mem_reg;
  logic             acarry_reg, azero_reg;

  logic             carry_reg, carry_next;
  logic             zero_reg, zero_next;
  logic             we_reg, we_next;
  logic [RA_W-1:0]  waddr_reg, waddr_next;
  logic [WIDTH-1:0] wdata_reg, wdata_next;
  logic             pcw_reg, pcw_next;
  logic             done_reg, done_next;
  logic             skip_reg, skip_next;

  logic       known_op;
  logic [1:0] eff_cz;
  logic       exec;

  // Only the ADD and NAND groups honour cz; everything else executes unconditionally.
  assign known_op = (op_reg <= OP_LW);
  assign eff_cz   = (op_reg == OP_ADD || op_reg == OP_NAND) ? cz_reg : 2'b00;
  assign exec     = (eff_cz == 2'b10) ? carry_reg :
                    (eff_cz == 2'b01) ? zero_reg  : 1'b1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg  <= IDLE;
      op_reg     <= '0;
      cz_reg     <= '0;
      dest_reg   <= '0;
      alu_reg    <= '0;
      mem_reg    <= '0;
      acarry_reg <= 1'b0;
      azero_reg  <= 1'b0;
      carry_reg  <= 1'b0;
      zero_reg   <= 1'b0;
      we_reg     <= 1'b0;
      waddr_reg  <= '0;
      wdata_reg  <= '0;
      pcw_reg    <= 1'b0;
      done_reg   <= 1'b0;
      skip_reg   <= 1'b0;
    end else begin
      state_reg <= state_next;
      if (state_reg == IDLE && in_valid) begin
        op_reg     <= opcode;
        cz_reg     <= cz;
        dest_reg   <= dest;
        alu_reg    <= alu_out;
        mem_reg    <= mem_data;
        acarry_reg <= alu_carry;
        azero_reg  <= alu_zero;
      end
      carry_reg <= carry_next;
      zero_reg  <= zero_next;
      we_reg    <= we_next;
      waddr_reg <= waddr_next;
      wdata_reg <= wdata_next;
      pcw_reg   <= pcw_next;
      done_reg  <= done_next;
      skip_reg  <= skip_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (in_valid) state_next = EVAL;
      EVAL:    state_next = (exec && known_op) ? WRITE : IDLE;
      WRITE:   if (rf_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    carry_next = carry_reg;
    zero_next  = zero_reg;
    we_next    = we_reg;
    waddr_next = waddr_reg;
    wdata_next = wdata_reg;
    pcw_next   = pcw_reg;
    done_next  = 1'b0;
    skip_next  = 1'b0;
    case (state_reg)
      EVAL: begin
        if (!exec) begin
          done_next = 1'b1;
          skip_next = 1'b1;
        end else if (!known_op) begin
          done_next = 1'b1;
        end else begin
          case (op_reg)
            OP_ADD, OP_ADI: begin
              carry_next = acarry_reg;
              zero_next  = azero_reg;
            end
            OP_NAND: zero_next = azero_reg;
            OP_LW:   zero_next = (mem_reg == '0);
            default: ;
          endcase
          we_next    = 1'b1;
          waddr_next = dest_reg;
          wdata_next = (op_reg == OP_LW) ? mem_reg : alu_reg;
          pcw_next   = (dest_reg == RA_W'(7));
        end
      end
      WRITE: begin
        if (rf_ready) begin
          we_next   = 1'b0;
          pcw_next  = 1'b0;
          done_next = 1'b1;
        end
      end
      default: ;
    endcase
  end

  assign in_ready   = (state_reg == IDLE);
  assign rf_we      = we_reg;
  assign rf_waddr   = waddr_reg;
  assign rf_wdata   = wdata_reg;
  assign pc_write   = pcw_reg;
  assign carry_flag = carry_reg;
  assign zero_flag  = zero_reg;
  assign done       = done_reg;
  assign skipped    = skip_reg;

endmodule

// File: tb/tb_alu_flag_writeback.sv
// Directed bench for alu_flag_writeback: hand-computed flags, writes and handshake timing.
module tb_alu_flag_writeback;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [3:0]  opcode = '0;
  logic [1:0]  cz = '0;
  logic [2:0]  dest = '0;
  logic [15:0] alu_out = '0;
  logic        alu_carry = 1'b0;
  logic        alu_zero = 1'b0;
  logic [15:0] mem_data = '0;
  logic        rf_we;
  logic        rf_ready = 1'b1;
  logic [2:0]  rf_waddr;
  logic [15:0] rf_wdata;
  logic        pc_write;
  logic        carry_flag;
  logic        zero_flag;
  logic        done;
  logic        skipped;

  int checks = 0;
  int fails = 0;

  alu_flag_writeback #(.WIDTH(16), .RA_W(3)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .cz(cz), .dest(dest), .alu_out(alu_out),
    .alu_carry(alu_carry), .alu_zero(alu_zero), .mem_data(mem_data),
    .rf_we(rf_we), .rf_ready(rf_ready), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pc_write(pc_write), .carry_flag(carry_flag), .zero_flag(zero_flag),
    .done(done), .skipped(skipped)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents one transaction; returns #1 after the accepting edge with in_valid dropped.
  task automatic issue(input logic [3:0] op, input logic [1:0] c, input logic [2:0] d,
                       input logic [15:0] alu, input logic ac, input logic az,
                       input logic [15:0] mem);
    opcode = op; cz = c; dest = d; alu_out = alu; alu_carry = ac; alu_zero = az;
    mem_data = mem; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
    checks++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
    checks++; if (rf_we !== 1'b0) begin fails++; $display("FAIL reset_rf_we: got %b want 0", rf_we); end
    checks++; if ({carry_flag, zero_flag} !== 2'b00) begin fails++; $display("FAIL reset_flags: got %b want 00", {carry_flag, zero_flag}); end
    checks++; if ({rf_waddr, rf_wdata} !== 19'h0) begin fails++; $display("FAIL reset_waddr_wdata: got %h want 0", {rf_waddr, rf_wdata}); end
    checks++; if ({pc_write, done, skipped} !== 3'b000) begin fails++; $display("FAIL reset_pcw_done_skip: got %b want 000", {pc_write, done, skipped}); end
  endtask

  task automatic test_add();
    rf_ready = 1'b1;
    issue(4'b0000, 2'b00, 3'd3, 16'h0000, 1'b1, 1'b1, 16'h5A5A);
    checks++; if (in_ready !== 1'b0) begin fails++; $display("FAIL add_in_ready_eval: got %b want 0", in_ready); end
    tick();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd3, 16'h0000}) begin fails++; $display("FAIL add_write: got we=%b a=%0d d=%h want we=1 a=3 d=0000", rf_we, rf_waddr, rf_wdata); end
    checks++; if ({carry_flag, zero_flag} !== 2'b11) begin fails++; $display("FAIL add_flags: got %b want 11", {carry_flag, zero_flag}); end
    checks++; if (done !== 1'b0) begin fails++; $display("FAIL add_done_early: got %b want 0", done); end
    tick();
    checks++; if ({rf_we, done, skipped, in_ready} !== 4'b0101) begin fails++; $display("FAIL add_retire: got we,done,skip,rdy=%b want 0101", {rf_we, done, skipped, in_ready}); end
  endtask

  task automatic test_adc_back_to_back();
    issue(4'b0000, 2'b10, 3'd1, 16'h1234, 1'b0, 1'b0, 16'h0000);
    tick();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd1, 16'h1234}) begin fails++; $display("FAIL adc_write: got we=%b a=%0d d=%h want we=1 a=1 d=1234", rf_we, rf_waddr, rf_wdata); end
    checks++; if ({carry_flag, zero_flag} !== 2'b00) begin fails++; $display("FAIL adc_flags: got %b want 00", {carry_flag, zero_flag}); end
    tick();
    checks++; if ({done, skipped} !== 2'b10) begin fails++; $display("FAIL adc_done: got %b want 10", {done, skipped}); end
    // Second ADC sees C=0 from the first one and must skip.
    issue(4'b0000, 2'b10, 3'd2, 16'h5555, 1'b1, 1'b1, 16'h0000);
    tick();
    checks++; if ({done, skipped, rf_we} !== 3'b110) begin fails++; $display("FAIL adc_skip: got done,skip,we=%b want 110", {done, skipped, rf_we}); end
    checks++; if ({carry_flag, zero_flag, in_ready} !== 3'b001) begin fails++; $display("FAIL adc_skip_flags: got C,Z,rdy=%b want 001", {carry_flag, zero_flag, in_ready}); end
  endtask

  task automatic test_nand();
    issue(4'b0010, 2'b01, 3'd4, 16'hAAAA, 1'b1, 1'b1, 16'h0000);
    tick();
    checks++; if ({done, skipped, rf_we} !== 3'b110) begin fails++; $display("FAIL ndz_skip: got done,skip,we=%b want 110", {done, skipped, rf_we}); end
    issue(4'b0010, 2'b00, 3'd4, 16'h0000, 1'b1, 1'b1, 16'h0000);
    tick();
    checks++; if ({carry_flag, zero_flag} !== 2'b01) begin fails++; $display("FAIL ndu_flags: got %b want 01", {carry_flag, zero_flag}); end
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd4, 16'h0000}) begin fails++; $display("FAIL ndu_write: got we=%b a=%0d d=%h want we=1 a=4 d=0000", rf_we, rf_waddr, rf_wdata); end
    tick();
    issue(4'b0010, 2'b01, 3'd5, 16'hFFFF, 1'b1, 1'b0, 16'h0000);
    tick();
    checks++; if ({rf_we, rf_waddr, rf_wdata} !== {1'b1, 3'd5, 16'hFFFF}) begin fails++; $display("FAIL ndz_write: got we=%b a=%0d d=%h want we=1 a=5 d=ffff", rf_we, rf_waddr, rf_wdata); end
    checks++; if ({carry_flag, zero_flag} !== 2'b00) begin fails++; $display("FAIL ndz_flags: got %b want 00", {carry_flag, zero_flag}); end
    tick();
    checks++; if ({done, skipped} !== 2'b10) begin fails++; $display("FAIL ndz_done: got %b want 10", {done, skipped}); end
  endtask

  // LW to R7 with a stalled register file and junk presented on in_valid meanwhile.
  task automatic test_lw_stall();
    rf_ready = 1'b0;
    issue(4'b0100, 2'b10, 3'd7, 16'hBEEF, 1'b1, 1'b0, 16'h0000);
    opcode = 4'b0000; cz = 2'b00; dest = 3'd1; alu_out = 16'h1111;
    alu_carry = 1'b1; alu_zero = 1'b0; mem_data = 16'h2222; in_valid = 1'b1;
    tick();
    checks++; if ({rf_we, pc_write, rf_waddr, rf_wdata} !== {2'b11, 3'd7, 16'h0000}) begin fails++; $display("FAIL lw_write: got we=%b pcw=%b a=%0d d=%h want 1 1 7 0000", rf_we, pc_write, rf_waddr, rf_wdata); end
    checks++; if ({carry_flag, zero_flag} !== 2'b01) begin fails++; $display("FAIL lw_flags: got %b want 01", {carry_flag, zero_flag}); end
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if ({rf_we, pc_write, rf_waddr, rf_wdata, in_ready, done} !== {2'b11, 3'd7, 16'h0000, 2'b00}) begin
        fails++;
        $display("FAIL lw_hold[%0d]: got we=%b pcw=%b a=%0d d=%h rdy=%b done=%b want 1 1 7 0000 0 0",
                 i, rf_we, pc_write, rf_waddr, rf_wdata, in_ready, done);
      end
    end
    in_valid = 1'b0;
    rf_ready = 1'b1;
    tick();
    checks++; if ({rf_we, done, skipped, carry_flag, zero_flag} !== 5'b01001) begin fails++; $display("FAIL lw_retire: got we,done,skip,C,Z=%b want 01001", {rf_we, done, skipped, carry_flag, zero_flag}); end
    tick();
    checks++; if ({rf_we, done, in_ready} !== 3'b001) begin fails++; $display("FAIL lw_no_junk: got we,done,rdy=%b want 001", {rf_we, done, in_ready}); end
  endtask

  task automatic test_other_opcodes();
    // ADI ignores cz (C=0 would otherwise skip it).
    issue(4'b0001, 2'b10, 3'd2, 16'h7FFF, 1'b1, 1'b0, 16'h0000);
    tick();
    checks++; if ({rf_we, rf_wdata, carry_flag, zero_flag} !== {1'b1, 16'h7FFF, 2'b10}) begin fails++; $display("FAIL adi: got we=%b d=%h C=%b Z=%b want 1 7fff 1 0", rf_we, rf_wdata, carry_flag, zero_flag); end
    tick();
    issue(4'b0011, 2'b01, 3'd6, 16'hAB00, 1'b0, 1'b1, 16'h0000);
    tick();
    checks++; if ({rf_we, rf_waddr, rf_wdata, carry_flag, zero_flag} !== {1'b1, 3'd6, 16'hAB00, 2'b10}) begin fails++; $display("FAIL lhi: got we=%b a=%0d d=%h C=%b Z=%b want 1 6 ab00 1 0", rf_we, rf_waddr, rf_wdata, carry_flag, zero_flag); end
    tick();
    issue(4'b0101, 2'b00, 3'd3, 16'h0000, 1'b0, 1'b1, 16'h0000);
    tick();
    checks++; if ({done, skipped, rf_we, carry_flag, zero_flag} !== 5'b10010) begin fails++; $display("FAIL nowrite_op: got done,skip,we,C,Z=%b want 10010", {done, skipped, rf_we, carry_flag, zero_flag}); end
  endtask

  task automatic test_reset_mid_write();
    rf_ready = 1'b0;
    issue(4'b0000, 2'b00, 3'd6, 16'h4321, 1'b1, 1'b1, 16'h0000);
    tick();
    checks++; if (rf_we !== 1'b1) begin fails++; $display("FAIL mid_pre_we: got %b want 1", rf_we); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    checks++; if ({rf_we, carry_flag, zero_flag, in_ready, pc_write, done} !== 6'b000100) begin fails++; $display("FAIL mid_reset: got we,C,Z,rdy,pcw,done=%b want 000100", {rf_we, carry_flag, zero_flag, in_ready, pc_write, done}); end
    rf_ready = 1'b1;
    tick(); tick();
    checks++; if ({rf_we, done} !== 2'b00) begin fails++; $display("FAIL mid_no_write: got we,done=%b want 00", {rf_we, done}); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_adc_back_to_back();
    test_nand();
    test_lw_stall();
    test_other_opcodes();
    test_reset_mid_write();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/alu_flag_writeback.md
Name: alu_flag_writeback

Overview:
- Writeback stage directly downstream of the 16-bit ALU in the multicycle RISC datapath.
- Accepts one completed ALU or load result per transaction over a valid/ready handshake.
- Holds the architectural carry (C) and zero (Z) flag registers and evaluates the conditional-execute rules for ADC/ADZ/NDC/NDZ.
- Updates the flags and drives a held register-file write request until the register file accepts it.

Parameters:
WIDTH, 16, data width of result and register-file write data
RA_W, 3, register address width (8 GPRs, R7 = PC)

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  synchronous, active-high reset
in_valid  in  1  upstream result valid
in_ready  out  1  stage can accept a transaction
opcode  in  4  instruction opcode: 0000 ADD-group, 0001 ADI, 0010 NAND-group, 0011 LHI, 0100 LW; any other value is a no-write
cz  in  2  instruction condition bits: 00 unconditional, 10 carry-conditional, 01 zero-conditional; 11 is treated as 00
dest  in  RA_W  destination register
alu_out  in  WIDTH  ALU result
alu_carry  in  1  ALU carry out
alu_zero  in  1  ALU zero flag
mem_data  in  WIDTH  load data, used when opcode=0100
rf_we  out  1  register-file write request, held until accepted
rf_ready  in  1  register file accepts write this cycle
rf_waddr  out  RA_W  write address
rf_wdata  out  WIDTH  write data
pc_write  out  1  qualifies rf_we when rf_waddr==7
carry_flag  out  1  architectural C
zero_flag  out  1  architectural Z
done  out  1  one-cycle pulse when a transaction retires, whether written or skipped
skipped  out  1  valid with done: 1 = condition failed, nothing written

Behaviour:
- Reset:
  - state=IDLE; carry_flag=0, zero_flag=0.
  - rf_we=0, rf_waddr=0, rf_wdata=0, pc_write=0, done=0, skipped=0; in_ready=1 on the cycle after reset deasserts.
- FSM states: IDLE, EVAL, WRITE.
- IDLE:
  - in_ready=1.
  - On in_valid, capture opcode, cz, dest, alu_out, alu_carry, alu_zero, mem_data; go to EVAL.
  - in_ready=0 in EVAL and WRITE; inputs there are ignored.
- EVAL (one cycle):
  - Condition uses flag values as held at the start of EVAL, before this instruction's update.
  - exec = (cz==10) ? C : (cz==01) ? Z : 1.
  - cz is ignored for ADI, LHI and LW.
  - If exec=0: skip path. Pulse done=1 with skipped=1, leave flags unchanged, return to IDLE.
  - If exec=1, update flags on the EVAL edge:
    - ADD-group and ADI: C<=alu_carry, Z<=alu_zero.
    - NAND-group: Z<=alu_zero, C unchanged.
    - LW: Z<=(mem_data==0), C unchanged.
    - LHI: no flag change.
  - Write data: LW uses mem_data; all other opcodes use alu_out.
  - Opcodes other than 0000–0100: no flag change; pulse done=1 with skipped=0; return to IDLE.
  - Otherwise go to WRITE with rf_we=1 and rf_waddr/rf_wdata registered; pc_write=1 if dest==7.
- WRITE:
  - rf_we, rf_waddr, rf_wdata and pc_write are held stable while rf_ready=0, with no timeout.
  - On the cycle rf_ready=1: the write completes. Next cycle rf_we=0, done=1, skipped=0, state=IDLE.
- Latency:
  - Accept at edge N; flags visible after edge N+1.
  - rf_we high from edge N+1.
  - With rf_ready tied high, done pulses after edge N+2.
  - Next accept possible at edge N+3. Skipped transactions: done after N+1, next accept at N+2.
- Back-to-back: the second instruction's condition sees the first instruction's updated flags.
- Reset mid-operation (EVAL or WRITE): abort; no write is issued; flags are cleared; outputs take their reset values.
- rf_ready while rf_we=0 is ignored.

Test Plan:
- Reset, then ADD (0000/00) alu_out=0x0000, carry=1, zero=1, dest=3, rf_ready=1 -> rf_we after N+1 with waddr=3, wdata=0; C=1, Z=1; done after N+2, skipped=0.
- With C=1: ADC (cz=10) alu_out=0x1234 carry=0 zero=0 -> written, C=0, Z=0. Then ADC again -> done+skipped=1, no rf_we, flags unchanged.
- NDZ (0010/01) with Z=0 -> skipped. Then NDU alu_out=0 -> Z=1, C unchanged. Then NDZ alu_out=0xFFFF -> written, Z=0.
- LW dest=7 mem_data=0x0000 alu_out=0xBEEF -> wdata=0x0000, pc_write=1, Z=1, C unchanged; hold rf_ready=0 for 5 cycles -> outputs stable and in_ready=0 throughout.
- Assert reset during WRITE with rf_ready=0 -> next cycle rf_we=0, C=Z=0, in_ready=1; no write observed.
- Drive in_valid during EVAL/WRITE with different data -> ignored; retired transaction matches the first capture only.
